unary_window_counter: RTL and testbench
=======================================

// Module: unary_window_counter
// PURPOSE
//  - Unary-to-binary back end for the scaled-add datapath. Consumes the 1-bit unary stream
//    produced by the scaled adder (its oC), and counts ones over a fixed window of 2**BWIDTH cycles.
//  - Presents the binary count with a one-cycle valid pulse.
//  - Start/busy handshake lets a testbench or controller frame one conversion per window.
// PARAMETERS
//  - BWIDTH  8  window length = 2**BWIDTH cycles; result width BWIDTH+1 (holds full count 2**BWIDTH)
// PORTS
//  - iClk     in   1         clock, rising edge
//  - iRstN    in   1         reset, asynchronous, active-low
//  - iStart   in   1         request a conversion; sampled only in IDLE or DONE
//  - iBit     in   1         unary stream bit (from scaled-adder oC)
//  - oBusy    out  1         1 while in RUN
//  - oValid   out  1         1-cycle pulse: oCount updated this cycle
//  - oCount   out  BWIDTH+1  ones count of last completed window; held until next completion
// BEHAVIOUR
//  - Reset values: FSM=IDLE, oBusy=0, oValid=0, oCount=0, internal ones/cycle counters=0.
//  - FSM states: IDLE, RUN, DONE.
//    - IDLE: iStart=1 -> RUN; clear ones and cycle counters.
//    - RUN: each cycle, ones += iBit and cyc += 1.
//      - On the cycle with cyc == 2**BWIDTH-1 (last sample): oCount <= ones + iBit, then -> DONE.
//    - DONE: oValid=1 for exactly this cycle.
//      - iStart=1 -> RUN (back-to-back, counters cleared, no idle gap); else -> IDLE.
//  - Timing: iStart high in IDLE at edge k. Samples are iBit at edges k+1 .. k+2**BWIDTH.
//    oValid is high in the cycle after edge k+2**BWIDTH.
//  - iStart during RUN is ignored; the window is never restarted or extended.
//  - iBit outside RUN is ignored.
//  - Arithmetic: ones counter is BWIDTH+1 bits and cannot overflow (max 2**BWIDTH).
//    The cycle counter is BWIDTH bits and wraps to 0 at window end.
//  - Reset asserted mid-RUN: immediate return to reset values, partial count discarded,
//    no oValid emitted.
//  - oBusy is a registered decode of state RUN; oValid is a registered decode of state DONE.
// CONFIGURATION
//  - Macro UNARY_WIN_BIPOLAR_EN:
//    - Defined: oCount is two's complement, value = ones - 2**(BWIDTH-1), range
//      -2**(BWIDTH-1) .. +2**(BWIDTH-1). This is bipolar value x scaled by 2**(BWIDTH-1).
//      Reset value of oCount is still 0.
//    - Undefined: oCount is unsigned ones count (unipolar). Default.
// STRUCTURE
//  - Shared package / include: FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the
//    window-length function 2**BWIDTH, reused by other unary-to-binary stages.
//  - One natural sub-module, unary_win_timer: the BWIDTH-bit cycle counter with clear input and
//    last-cycle flag.
//  - Ones accumulation, FSM and output registers stay in the top.
// TESTING (bench with BWIDTH=4, window 16 cycles)
//  - All-ones: iBit=1 for 16 cycles after iStart -> single oValid pulse, oCount=5'd16, oBusy low after.
//  - All-zeros: iBit=0 -> oCount=0; with UNARY_WIN_BIPOLAR_EN -> oCount=5'b11000 (-8).
//  - Alternating 1010...: -> oCount=8; bipolar -> 0.
//  - Start ignored: iStart pulsed again at window cycle 5 -> exactly one oValid, 17 cycles after first
//    iStart, count unaffected.
//  - Back-to-back: iStart held high -> oValid every 17 cycles.
//    Windows of all-ones then all-zeros give 16 then 0.
//  - Reset mid-RUN: iRstN low at window cycle 9 -> oBusy=0, oCount=0, no oValid.
//    A new iStart then gives a full correct 16-cycle result.

Source files
------------

// File: rtl/unary_window_counter_pkg.sv
// unary_window_counter_pkg: FSM encodings and window-length helper shared by unary-to-binary stages
package unary_window_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } uwc_state_t;

    function automatic int win_len(input int bw);
        return 1 << bw;
    endfunction

endpackage

// File: rtl/unary_win_timer.sv
// unary_win_timer: BWIDTH-bit window cycle counter with clear and last-sample flag
module unary_win_timer import unary_window_counter_pkg::*; #(
    parameter int BWIDTH = 8
) (
    input  logic iClk,
    input  logic iRstN,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam logic [BWIDTH-1:0] LAST_CYC = BWIDTH'(win_len(BWIDTH) - 1);

    logic [BWIDTH-1:0] cyc;

    // count enabled cycles; natural wrap to 0 after the last sample
    always_ff @(posedge iClk or negedge iRstN)
        if (!iRstN) cyc <= '0;
        else if (clr) cyc <= '0;
        else if (en) cyc <= cyc + 1'b1;

    assign last = en && (cyc == LAST_CYC);

endmodule

// File: rtl/unary_window_counter.sv
// unary_window_counter: counts ones of a unary stream over 2**BWIDTH cycles, start/busy/valid framed
// Optional UNARY_WIN_BIPOLAR_EN: report ones - 2**(BWIDTH-1) as two's complement
module unary_window_counter import unary_window_counter_pkg::*; #(
    parameter int BWIDTH = 8
) (
    input  logic            iClk,
    input  logic            iRstN,
    input  logic            iStart,
    input  logic            iBit,
    output logic            oBusy,
    output logic            oValid,
    output logic [BWIDTH:0] oCount
);

    uwc_state_t      state, state_nx;
    logic [BWIDTH:0] ones, sum, result;
    logic            run, start_acc, last;

    assign run       = state == RUN;
    assign start_acc = !run && iStart;
    assign sum       = ones + (BWIDTH+1)'(iBit);

`ifdef UNARY_WIN_BIPOLAR_EN
    localparam logic [BWIDTH:0] HALF = (BWIDTH+1)'(win_len(BWIDTH) / 2);
    assign result = sum - HALF;
`else
    assign result = sum;
`endif

    unary_win_timer #(.BWIDTH(BWIDTH)) u_timer (
        .iClk (iClk),
        .iRstN(iRstN),
        .clr  (start_acc),
        .en   (run),
        .last (last)
    );

    // next state: RUN holds until its last sample; IDLE and DONE both accept a start
    always_comb
        state_nx = run ? (last ? DONE : RUN) : (iStart ? RUN : IDLE);

    // state, ones accumulator and registered outputs
    always_ff @(posedge iClk or negedge iRstN)
        if (!iRstN) begin
            state  <= IDLE;
            ones   <= '0;
            oBusy  <= 1'b0;
            oValid <= 1'b0;
            oCount <= '0;
        end else begin
            state  <= state_nx;
            ones   <= start_acc ? '0 : run ? sum : ones;
            oBusy  <= state_nx == RUN;
            oValid <= state_nx == DONE;
            if (run && last) oCount <= result;
        end

endmodule

// File: tb/tb_unary_window_counter.sv
// tb_unary_window_counter: randomized scoreboard bench for unary_window_counter (BWIDTH=4)
module tb_unary_window_counter;

    localparam int BW  = 4;
    localparam int WIN = 16;

    logic          iClk = 1'b0;
    logic          iRstN = 1'b0;
    logic          iStart = 1'b0;
    logic          iBit = 1'b0;
    logic          oBusy, oValid;
    logic [BW:0]   oCount;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        logic [BW:0] cnt;
        int          at;
    } exp_t;

    exp_t q[$];
    logic [BW:0] held = '0;

    unary_window_counter #(.BWIDTH(BW)) dut (
        .iClk  (iClk),
        .iRstN (iRstN),
        .iStart(iStart),
        .iBit  (iBit),
        .oBusy (oBusy),
        .oValid(oValid),
        .oCount(oCount)
    );

    always #5 iClk = ~iClk;

    always @(posedge iClk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [BW:0] model(input logic [WIN-1:0] bits);
        int n;
        n = $countones(bits);
`ifdef UNARY_WIN_BIPOLAR_EN
        n = n - WIN / 2;
`endif
        return (BW+1)'(n);
    endfunction

    // monitor: pop expected result whenever the DUT reports one, check hold otherwise
    always @(negedge iClk) begin
        exp_t e;
        if (!iRstN) begin
            held = '0;
            chk("reset_count", 32'(oCount), 0);
        end else if (oValid) begin
            if (q.size() == 0) chk("unexpected_valid", 1, 0);
            else begin
                e = q.pop_front();
                chk("count", 32'(oCount), 32'(e.cnt));
                chk("valid_cycle", cyc, e.at);
                chk("busy_at_valid", 32'(oBusy), 0);
                held = e.cnt;
            end
        end else
            chk("count_hold", 32'(oCount), 32'(held));
    end

    // one conversion: start at next edge k, samples at k+1..k+16; restart pulses during RUN are random
    task automatic do_window(input logic [WIN-1:0] bits);
        int k;
        exp_t e;
        @(negedge iClk);
        iStart = 1'b1;
        iBit = 1'($urandom);
        k = cyc + 1;
        for (int i = 0; i < WIN; i++) begin
            @(negedge iClk);
            chk("busy_in_run", 32'(oBusy), 1);
            iStart = (i == 5) ? 1'b1 : 1'($urandom);
            iBit = bits[i];
        end
        e.cnt = model(bits);
        e.at = k + WIN;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge iClk);
            iStart = 1'b0;
            iBit = 1'($urandom);
            if (i > 0 || q.size() == 0) chk("busy_idle", 32'(oBusy), 0);
        end
    endtask

    initial begin
        logic [WIN-1:0] b;
        int t0;
        repeat (3) @(negedge iClk);
        chk("rst_busy", 32'(oBusy), 0);
        chk("rst_valid", 32'(oValid), 0);
        chk("rst_count", 32'(oCount), 0);
        iRstN = 1'b1;
        idle(2);

        do_window(16'hFFFF);
        idle(3);
        do_window(16'h0000);
        idle(2);
        do_window(16'h5555);
        idle(2);
        do_window(16'hAAAA);
        idle(2);
        // back-to-back: DONE takes the start directly, 17 cycles per window
        do_window(16'hFFFF);
        do_window(16'h0000);
        do_window(16'h0F0F);
        idle(3);

        // reset in the middle of a window: partial count lost, nothing reported
        @(negedge iClk);
        iStart = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge iClk);
            iStart = 1'($urandom);
            iBit = 1'b1;
        end
        @(negedge iClk);
        #2 iRstN = 1'b0;
        #1;
        chk("midrun_busy", 32'(oBusy), 0);
        chk("midrun_valid", 32'(oValid), 0);
        chk("midrun_count", 32'(oCount), 0);
        iStart = 1'b0;
        repeat (2) @(negedge iClk);
        iRstN = 1'b1;
        idle(2);
        do_window(16'hFFFF);
        idle(2);

        for (int n = 0; n < 20; n++) begin
            b = WIN'($urandom);
            do_window(b);
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
        end
        idle(2);

        t0 = cyc;
        while (q.size() != 0 && cyc - t0 < 40) @(negedge iClk);
        chk("drain", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
